gig_eth_tx_arbiter: RTL and testbench

//  Round-robin frame scheduler sharing one gig_eth_mac TX client port between
//  NUM_PORTS requesters in the tx_clk domain. Grants whole frames only,

---
 rtl/gig_eth_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_gig_eth_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gig_eth_tx_arbiter.sv
// rtl/gig_eth_tx_arbiter.sv - round-robin whole-frame scheduler for one gig_eth_mac TX client port
//
// Shares the MAC TX client interface between NUM_PORTS requesters. A port is
// granted a complete frame, the MAC ack is routed back to it alone, and a
// frame running past the byte limit is cut with an underrun.
//
// Ports:
//   tx_clk, reset          clock, asynchronous active-high reset
//   arb_en                 enables new grants (current frame always completes)
//   conf_jumbo_en          selects the jumbo byte limit, sampled at grant
//   req_data/dvld/underrun per-port client inputs, port i byte at [8i+7:8i]
//   req_ack                MAC ack steered to the granted port
//   mac_tx_*               MAC client interface
//   grant_vld, grant_idx   a port owns the MAC, and which one
//   stat_abort             1-cycle pulse when an oversize frame is aborted
module gig_eth_tx_arbiter #(
    parameter int NUM_PORTS               = 4,
    parameter int PORT_W                  = 2,
    parameter int MAX_FRAME_SIZE_STANDARD = 1522,
    parameter int MAX_FRAME_SIZE_JUMBO    = 9022,
    parameter int CNT_W                   = 14
) (
    input  logic                   tx_clk,
    input  logic                   reset,
    input  logic                   arb_en,
    input  logic                   conf_jumbo_en,
    input  logic [8*NUM_PORTS-1:0] req_data,
    input  logic [NUM_PORTS-1:0]   req_dvld,
    input  logic [NUM_PORTS-1:0]   req_underrun,
    output logic [NUM_PORTS-1:0]   req_ack,
    output logic [7:0]             mac_tx_data,
    output logic                   mac_tx_dvld,
    input  logic                   mac_tx_ack,
    output logic                   mac_tx_underrun,
    output logic                   grant_vld,
    output logic [PORT_W-1:0]      grant_idx,
    output logic                   stat_abort
);

    localparam logic [CNT_W-1:0] LIM_STD   = CNT_W'(MAX_FRAME_SIZE_STANDARD);
    localparam logic [CNT_W-1:0] LIM_JUMBO = CNT_W'(MAX_FRAME_SIZE_JUMBO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_XFER,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [PORT_W-1:0] r_grant_idx;
    logic [PORT_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [CNT_W-1:0]  r_limit;

    logic [PORT_W-1:0] w_pick;
    logic              w_found;
    logic [PORT_W:0]   w_inc;
    logic [PORT_W-1:0] w_next_ptr;
    logic [7:0]        w_g_data;
    logic              w_g_dvld;
    logic              w_g_underrun;
    logic              w_at_limit;
    logic              w_route_ack;

    // First requesting port at or after r_rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin : rr_search
        logic [PORT_W:0] v_idx;
        v_idx   = '0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            v_idx = {1'b0, r_rr_ptr} + (PORT_W+1)'(i);
            if (v_idx >= (PORT_W+1)'(NUM_PORTS)) begin
                v_idx = v_idx - (PORT_W+1)'(NUM_PORTS);
            end
            if (!w_found && req_dvld[v_idx[PORT_W-1:0]]) begin
                w_pick  = v_idx[PORT_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_inc      = {1'b0, r_grant_idx} + (PORT_W+1)'(1);
    assign w_next_ptr = (w_inc >= (PORT_W+1)'(NUM_PORTS)) ? '0 : w_inc[PORT_W-1:0];

    // Granted port's client signals and ack steering.
    always_comb begin
        w_g_data     = '0;
        w_g_dvld     = 1'b0;
        w_g_underrun = 1'b0;
        req_ack      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant_idx == PORT_W'(i)) begin
                w_g_data     = req_data[8*i +: 8];
                w_g_dvld     = req_dvld[i];
                w_g_underrun = req_underrun[i];
                req_ack[i]   = w_route_ack & mac_tx_ack;
            end
        end
    end

    assign w_at_limit = (r_byte_cnt == r_limit);
    assign grant_idx  = r_grant_idx;

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        mac_tx_data     = '0;
        mac_tx_dvld     = 1'b0;
        mac_tx_underrun = 1'b0;
        stat_abort      = 1'b0;
        grant_vld       = 1'b0;
        w_route_ack     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arb_en && w_found) begin
                    w_next_state = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                grant_vld       = 1'b1;
                w_route_ack     = 1'b1;
                mac_tx_data     = w_g_data;
                mac_tx_dvld     = w_g_dvld;
                mac_tx_underrun = w_g_underrun;
                // A port dropping dvld before the ack has withdrawn its frame.
                if (!w_g_dvld) begin
                    w_next_state = S_GAP;
                end else if (mac_tx_ack) begin
                    w_next_state = S_XFER;
                end
            end
            S_XFER: begin
                grant_vld       = 1'b1;
                w_route_ack     = 1'b1;
                mac_tx_data     = w_g_data;
                mac_tx_dvld     = w_g_dvld;
                mac_tx_underrun = w_g_underrun;
                if (!w_g_dvld) begin
                    w_next_state = S_GAP;
                end else if (w_at_limit) begin
                    // One byte past the limit: make the MAC abort the frame.
                    mac_tx_dvld     = 1'b1;
                    mac_tx_underrun = 1'b1;
                    stat_abort      = 1'b1;
                    w_next_state    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                grant_vld = 1'b1;
                if (!w_g_dvld) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_byte_cnt  <= '0;
            r_limit     <= LIM_STD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arb_en && w_found) begin
                        r_grant_idx <= w_pick;
                        r_limit     <= conf_jumbo_en ? LIM_JUMBO : LIM_STD;
                        r_byte_cnt  <= '0;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_g_dvld && mac_tx_ack) begin
                        r_byte_cnt <= CNT_W'(1);
                    end
                end
                S_XFER: begin
                    // Saturates at the limit; the frame is aborted there anyway.
                    if (w_g_dvld && !w_at_limit) begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gig_eth_tx_arbiter.sv
// tb/tb_gig_eth_tx_arbiter.sv - scoreboard bench for gig_eth_tx_arbiter
module tb_gig_eth_tx_arbiter;

    localparam int NP      = 4;
    localparam int LIM_STD = 1522;
    localparam int LIM_JMB = 9022;

    logic            tx_clk = 1'b0;
    logic            reset;
    logic            arb_en;
    logic            conf_jumbo_en;
    logic [8*NP-1:0] req_data;
    logic [NP-1:0]   req_dvld;
    logic [NP-1:0]   req_underrun;
    logic [NP-1:0]   req_ack;
    logic [7:0]      mac_tx_data;
    logic            mac_tx_dvld;
    logic            mac_tx_ack;
    logic            mac_tx_underrun;
    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic            stat_abort;

    gig_eth_tx_arbiter dut (
        .tx_clk          (tx_clk),
        .reset           (reset),
        .arb_en          (arb_en),
        .conf_jumbo_en   (conf_jumbo_en),
        .req_data        (req_data),
        .req_dvld        (req_dvld),
        .req_underrun    (req_underrun),
        .req_ack         (req_ack),
        .mac_tx_data     (mac_tx_data),
        .mac_tx_dvld     (mac_tx_dvld),
        .mac_tx_ack      (mac_tx_ack),
        .mac_tx_underrun (mac_tx_underrun),
        .grant_vld       (grant_vld),
        .grant_idx       (grant_idx),
        .stat_abort      (stat_abort)
    );

    always #4 tx_clk = ~tx_clk;

    int n_total = 0;
    int n_pass  = 0;
    int q_grant[$];
    int q_byte[$];

    int f_len[NP];
    int f_pos[NP];
    int f_wd[NP];
    int pend_cnt[NP];
    int pend_len[NP];
    int pend_wd[NP];
    int ack_cnt[NP];
    bit acked[NP];
    bit s_ack[NP];
    bit m_busy;
    bit m_ack_next;
    int m_seen;
    int ack_delay = 2;
    bit prev_gv;
    int abort_cnt;

    function automatic logic [7:0] bval(int p, int pos);
        return 8'((p * 37 + pos * 3 + pos / 256) % 256);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push_frame(int p, int len, int lim);
        for (int k = 0; k < len && k <= lim; k++) begin
            q_byte.push_back(((k == lim) ? 256 : 0) + int'(bval(p, k)));
        end
    endtask

    task automatic take_byte();
        int eb;
        eb = (q_byte.size() > 0) ? q_byte.pop_front() : -1;
        chk("mac_byte", int'({mac_tx_underrun, mac_tx_data}), eb);
    endtask

    // One clock: requesters and MAC model drive at negedge, outputs sampled 1 ns later.
    task automatic cycle();
        int eg;
        @(negedge tx_clk);
        for (int p = 0; p < NP; p++) begin
            if (f_len[p] == 0) begin
                if (pend_cnt[p] > 0) begin
                    pend_cnt[p]--;
                    f_len[p] = pend_len[p];
                    f_pos[p] = 0;
                    f_wd[p]  = pend_wd[p];
                    acked[p] = 1'b0;
                end
            end else if (s_ack[p]) begin
                acked[p] = 1'b1;
                f_pos[p] = 1;
            end else if (acked[p]) begin
                f_pos[p]++;
            end else if (f_wd[p] > 0) begin
                f_wd[p]--;
                if (f_wd[p] == 0) f_len[p] = 0;
            end
            if (acked[p] && f_pos[p] >= f_len[p]) begin
                f_len[p] = 0;
                acked[p] = 1'b0;
            end
            req_dvld[p]        = (f_len[p] != 0);
            req_data[8*p +: 8] = bval(p, f_pos[p]);
        end
        mac_tx_ack = m_ack_next;
        #1;
        if (grant_vld && !prev_gv) begin
            eg = (q_grant.size() > 0) ? q_grant.pop_front() : -1;
            chk("grant_idx", int'(grant_idx), eg);
        end
        prev_gv = grant_vld;
        if (mac_tx_ack) begin
            take_byte();
            m_busy = !mac_tx_underrun;
        end else if (m_busy) begin
            if (mac_tx_dvld) begin
                take_byte();
                if (mac_tx_underrun) m_busy = 1'b0;
            end else begin
                m_busy = 1'b0;
            end
        end
        m_ack_next = 1'b0;
        if (!m_busy && !mac_tx_ack && mac_tx_dvld) begin
            m_seen++;
            if (m_seen >= ack_delay) begin
                m_ack_next = 1'b1;
                m_seen     = 0;
            end
        end else begin
            m_seen = 0;
        end
        for (int p = 0; p < NP; p++) begin
            s_ack[p] = req_ack[p];
            if (req_ack[p]) ack_cnt[p]++;
        end
        if (stat_abort) abort_cnt++;
    endtask

    function automatic bit all_idle();
        bit r;
        r = !grant_vld && !mac_tx_dvld;
        for (int p = 0; p < NP; p++) begin
            if (f_len[p] != 0 || pend_cnt[p] != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_quiet(int budget, string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = all_idle();
        end
        chk({tag, "_done"}, int'(done), 1);
        cycle();
    endtask

    task automatic start(int p, int len, int wd, int cnt);
        pend_len[p] = len;
        pend_wd[p]  = wd;
        pend_cnt[p] = cnt;
    endtask

    task automatic clr_acks();
        for (int p = 0; p < NP; p++) ack_cnt[p] = 0;
    endtask

    task automatic bench_clear();
        for (int p = 0; p < NP; p++) begin
            f_len[p]    = 0;
            f_pos[p]    = 0;
            f_wd[p]     = 0;
            pend_cnt[p] = 0;
            pend_wd[p]  = 0;
            acked[p]    = 1'b0;
            s_ack[p]    = 1'b0;
        end
        q_grant.delete();
        q_byte.delete();
        m_busy     = 1'b0;
        m_seen     = 0;
        m_ack_next = 1'b0;
        prev_gv    = 1'b0;
        mac_tx_ack = 1'b0;
        req_dvld   = '0;
        req_data   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        arb_en        = 1'b0;
        conf_jumbo_en = 1'b0;
        req_underrun  = '0;
        abort_cnt     = 0;
        bench_clear();
        repeat (3) @(negedge tx_clk);
        #1;
        chk("rst_grant_vld", int'(grant_vld), 0);
        chk("rst_grant_idx", int'(grant_idx), 0);
        chk("rst_mac_dvld", int'(mac_tx_dvld), 0);
        chk("rst_mac_data", int'(mac_tx_data), 0);
        chk("rst_mac_underrun", int'(mac_tx_underrun), 0);
        chk("rst_req_ack", int'(req_ack), 0);
        chk("rst_stat_abort", int'(stat_abort), 0);
        reset  = 1'b0;
        arb_en = 1'b1;

        // Single 64-byte frame from port 2.
        clr_acks();
        start(2, 64, 0, 1);
        q_grant.push_back(2);
        push_frame(2, 64, LIM_STD);
        wait_quiet(200, "t1");
        for (int p = 0; p < NP; p++) chk($sformatf("t1_ack_cnt%0d", p), ack_cnt[p], (p == 2) ? 1 : 0);
        chk("t1_bytes_left", q_byte.size(), 0);
        chk("t1_grant_vld_idle", int'(grant_vld), 0);

        // Port 0 withdraws before the ack: no ack, no bytes, rr_ptr moves to 1.
        clr_acks();
        start(0, 10, 2, 1);
        q_grant.push_back(0);
        wait_quiet(50, "t4");
        chk("t4_ack_cnt0", ack_cnt[0], 0);
        chk("t4_grants_left", q_grant.size(), 0);

        // Ports 0 and 1 together: port 1 first proves rr_ptr=1.
        start(0, 4, 0, 1);
        start(1, 4, 0, 1);
        q_grant.push_back(1);
        q_grant.push_back(0);
        push_frame(1, 4, LIM_STD);
        push_frame(0, 4, LIM_STD);
        wait_quiet(100, "t4b");
        chk("t4b_bytes_left", q_byte.size(), 0);

        // Oversize frame with standard limit, exact-limit frame, then jumbo.
        start(1, 1523, 0, 1);
        q_grant.push_back(1);
        push_frame(1, 1523, LIM_STD);
        wait_quiet(2000, "t3_abort");
        chk("t3_abort_cnt", abort_cnt, 1);
        chk("t3_bytes_left", q_byte.size(), 0);
        start(1, 1522, 0, 1);
        q_grant.push_back(1);
        push_frame(1, 1522, LIM_STD);
        wait_quiet(2000, "t3_exact");
        chk("t3_exact_abort_cnt", abort_cnt, 1);
        conf_jumbo_en = 1'b1;
        start(1, 1523, 0, 1);
        q_grant.push_back(1);
        push_frame(1, 1523, LIM_JMB);
        wait_quiet(2000, "t3_jumbo");
        chk("t3_jumbo_abort_cnt", abort_cnt, 1);
        chk("t3_jumbo_bytes_left", q_byte.size(), 0);
        conf_jumbo_en = 1'b0;

        // arb_en dropped while port 3 transfers: frame completes, port 0 waits.
        clr_acks();
        start(3, 20, 0, 1);
        q_grant.push_back(3);
        push_frame(3, 20, LIM_STD);
        repeat (8) cycle();
        arb_en = 1'b0;
        start(0, 6, 0, 1);
        repeat (40) cycle();
        chk("t5_grant_vld_held", int'(grant_vld), 0);
        chk("t5_grants_left", q_grant.size(), 0);
        chk("t5_bytes_left", q_byte.size(), 0);
        chk("t5_ack_cnt0", ack_cnt[0], 0);
        chk("t5_ack_cnt3", ack_cnt[3], 1);
        arb_en = 1'b1;
        q_grant.push_back(0);
        push_frame(0, 6, LIM_STD);
        wait_quiet(60, "t5_resume");
        chk("t5_resume_bytes_left", q_byte.size(), 0);

        // Asynchronous reset in the middle of a port-2 frame.
        start(2, 40, 0, 1);
        q_grant.push_back(2);
        push_frame(2, 40, LIM_STD);
        repeat (10) cycle();
        chk("t6_pre_dvld", int'(mac_tx_dvld), 1);
        chk("t6_pre_grant_idx", int'(grant_idx), 2);
        reset = 1'b1;
        #1;
        chk("t6_dvld", int'(mac_tx_dvld), 0);
        chk("t6_data", int'(mac_tx_data), 0);
        chk("t6_grant_vld", int'(grant_vld), 0);
        chk("t6_grant_idx", int'(grant_idx), 0);
        chk("t6_req_ack", int'(req_ack), 0);
        bench_clear();
        repeat (2) @(negedge tx_clk);
        reset = 1'b0;

        // All ports busy after reset: strict 0,1,2,3,0,1,2,3 order.
        for (int p = 0; p < NP; p++) start(p, 8, 0, 2);
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                q_grant.push_back(p);
                push_frame(p, 8, LIM_STD);
            end
        end
        wait_quiet(600, "t2");
        chk("t2_grants_left", q_grant.size(), 0);
        chk("t2_bytes_left", q_byte.size(), 0);
        chk("t2_abort_cnt", abort_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
